// File: rtl/gen_pkg.sv
// Shared definitions for the frame sequencer and the downstream generator:
// FSM state encoding and the default segment lengths.
package gen_pkg;

  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN  = 16;
  localparam int DEF_SIZEGAP    = 4;
  localparam int DEF_SIZECNT    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STAT = 2'd1,
    ST_DYN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/dyn_hold_buf.sv
// One-entry holding buffer for dynamic words, with a bypass path that loads
// DYNREG straight from the input when a word arrives on the frame-start edge.
module dyn_hold_buf
  import gen_pkg::*;
#(
  parameter int WIDTH = DEF_SIZESRDYN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_dyn_valid,
  input  logic [WIDTH-1:0] i_dyn_data,
  output logic             o_dyn_ready,
  output logic [WIDTH-1:0] o_dynreg,
  output logic             o_underrun
);

  logic             r_full;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_dynreg;
  logic             r_underrun;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_full     <= 1'b0;
      r_buf      <= '0;
      r_dynreg   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (i_frame_start) begin
        if (r_full) begin
          r_dynreg <= r_buf;
          r_full   <= 1'b0;
        end else if (i_dyn_valid) begin
          r_dynreg <= i_dyn_data;
        end else begin
          r_underrun <= 1'b1;
        end
      end else if (!r_full && i_dyn_valid) begin
        r_buf  <= i_dyn_data;
        r_full <= 1'b1;
      end
    end
  end

  assign o_dyn_ready = ~r_full;
  assign o_dynreg    = r_dynreg;
  assign o_underrun  = r_underrun;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks IDLE -> STAT -> DYN -> GAP, drives registered segment
// selects and latches the static/dynamic words at each frame start.
module frame_sequencer
  import gen_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN  = DEF_SIZESRDYN,
  parameter int SIZEGAP    = DEF_SIZEGAP,
  parameter int SIZECNT    = DEF_SIZECNT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [SIZESRSTAT-1:0] STAT_DATA,
  input  logic                  DYN_VALID,
  input  logic [SIZESRDYN-1:0]  DYN_DATA,
  output logic                  DYN_READY,
  output logic                  SELSTAT,
  output logic                  SELDYN,
  output logic [SIZESRSTAT-1:0] STATREG,
  output logic [SIZESRDYN-1:0]  DYNREG,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  UNDERRUN
);

  localparam logic [SIZECNT-1:0] LD_STAT = SIZECNT'(SIZESRSTAT - 1);
  localparam logic [SIZECNT-1:0] LD_DYN  = SIZECNT'(SIZESRDYN - 1);
  localparam logic [SIZECNT-1:0] LD_GAP  = SIZECNT'(SIZEGAP - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [SIZECNT-1:0]      r_cnt;
  logic [SIZECNT-1:0]      w_next_cnt;
  logic                    w_cnt_zero;
  logic                    w_frame_start;
  logic                    r_selstat;
  logic                    r_seldyn;
  logic                    r_busy;
  logic                    r_frame_done;
  logic [SIZESRSTAT-1:0]   r_statreg;

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_next_state = ST_STAT;
          w_next_cnt   = LD_STAT;
        end
      end
      ST_STAT: begin
        if (w_cnt_zero) begin
          w_next_state = ST_DYN;
          w_next_cnt   = LD_DYN;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      ST_DYN: begin
        if (w_cnt_zero) begin
          w_next_state = ST_GAP;
          w_next_cnt   = LD_GAP;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          // START is only looked at here, so dropping it mid-frame never
          // shortens the frame in flight.
          w_next_state = START ? ST_STAT : ST_IDLE;
          w_next_cnt   = START ? LD_STAT : '0;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign w_frame_start = (w_next_state == ST_STAT) && (r_state != ST_STAT);

  // Outputs are flops loaded from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_selstat    <= 1'b0;
      r_seldyn     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_statreg    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_selstat    <= (w_next_state == ST_STAT);
      r_seldyn     <= (w_next_state == ST_DYN);
      r_busy       <= (w_next_state != ST_IDLE);
      r_frame_done <= (w_next_state == ST_GAP) && (w_next_cnt == '0);
      if (w_frame_start) begin
        r_statreg <= STAT_DATA;
      end
    end
  end

  dyn_hold_buf #(
    .WIDTH (SIZESRDYN)
  ) u_dyn_hold_buf (
    .i_clk         (CLK),
    .i_rst_n       (RST_N),
    .i_frame_start (w_frame_start),
    .i_dyn_valid   (DYN_VALID),
    .i_dyn_data    (DYN_DATA),
    .o_dyn_ready   (DYN_READY),
    .o_dynreg      (DYNREG),
    .o_underrun    (UNDERRUN)
  );

  assign SELSTAT    = r_selstat;
  assign SELDYN     = r_seldyn;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_frame_done;
  assign STATREG    = r_statreg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer: frame timing, dynamic-word
// handshake, bypass, underrun and reset behaviour.
module tb_frame_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [87:0] STAT_DATA;
  logic        DYN_VALID;
  logic [15:0] DYN_DATA;
  logic        DYN_READY;
  logic        SELSTAT;
  logic        SELDYN;
  logic [87:0] STATREG;
  logic [15:0] DYNREG;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        UNDERRUN;

  int errors = 0;
  int checks = 0;

  // per-cycle logs filled by run_window, index 0 = first sample after call
  logic        log_stat  [0:511];
  logic        log_busy  [0:511];
  logic        log_done  [0:511];
  logic        log_under [0:511];
  logic        log_ready [0:511];
  logic [15:0] log_dyn   [0:511];
  int n_stat, n_dyn, n_busy, n_done, n_under, n_both, done_idx;

  frame_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .STAT_DATA  (STAT_DATA),
    .DYN_VALID  (DYN_VALID),
    .DYN_DATA   (DYN_DATA),
    .DYN_READY  (DYN_READY),
    .SELSTAT    (SELSTAT),
    .SELDYN     (SELDYN),
    .STATREG    (STATREG),
    .DYNREG     (DYNREG),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .UNDERRUN   (UNDERRUN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Samples n negedges; drops START after sample drop_at and offers one word
  // right after sample feed_at (DYN_VALID low otherwise).
  task automatic run_window(input int n, input int drop_at, input int feed_at,
                            input logic [15:0] feed_data);
    n_stat = 0; n_dyn = 0; n_busy = 0; n_done = 0; n_under = 0; n_both = 0;
    done_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      log_stat[i]  = SELSTAT;
      log_busy[i]  = BUSY;
      log_done[i]  = FRAME_DONE;
      log_under[i] = UNDERRUN;
      log_ready[i] = DYN_READY;
      log_dyn[i]   = DYNREG;
      if (SELSTAT)    n_stat++;
      if (SELDYN)     n_dyn++;
      if (BUSY)       n_busy++;
      if (UNDERRUN)   n_under++;
      if (SELSTAT && SELDYN) n_both++;
      if (FRAME_DONE) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
      if (i == drop_at) START = 1'b0;
      if (i == feed_at) begin
        DYN_VALID = 1'b1;
        DYN_DATA  = feed_data;
      end else begin
        DYN_VALID = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; DYN_VALID = 1'b0; DYN_DATA = '0; STAT_DATA = '0;
    repeat (3) @(negedge CLK);
    checks++; if (SELSTAT !== 1'b0) begin errors++; $display("FAIL reset_selstat: got %b want 0", SELSTAT); end
    checks++; if (SELDYN !== 1'b0) begin errors++; $display("FAIL reset_seldyn: got %b want 0", SELDYN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", FRAME_DONE); end
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", UNDERRUN); end
    checks++; if (DYN_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", DYN_READY); end
    checks++; if (STATREG !== 88'h0) begin errors++; $display("FAIL reset_statreg: got %h want 0", STATREG); end
    checks++; if (DYNREG !== 16'h0) begin errors++; $display("FAIL reset_dynreg: got %h want 0", DYNREG); end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b want 0", BUSY); end
  endtask

  task automatic test_single_frame();
    DYN_VALID = 1'b1; DYN_DATA = 16'hABCD;
    @(negedge CLK);
    checks++; if (DYN_READY !== 1'b0) begin errors++; $display("FAIL preload_ready: got %b want 0", DYN_READY); end
    DYN_VALID = 1'b0;
    STAT_DATA = 88'h0123456789ABCDEFFEDCBA;
    START = 1'b1;
    run_window(112, 0, -1, 16'h0);
    checks++; if (n_stat !== 88) begin errors++; $display("FAIL single_selstat_len: got %0d want 88", n_stat); end
    checks++; if (n_dyn !== 16) begin errors++; $display("FAIL single_seldyn_len: got %0d want 16", n_dyn); end
    checks++; if (n_busy !== 108) begin errors++; $display("FAIL single_busy_len: got %0d want 108", n_busy); end
    checks++; if (n_done !== 1 || done_idx !== 107) begin errors++; $display("FAIL single_done: count %0d at %0d want 1 at 107", n_done, done_idx); end
    checks++; if (n_under !== 0) begin errors++; $display("FAIL single_underrun: got %0d want 0", n_under); end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL single_sel_overlap: got %0d want 0", n_both); end
    checks++; if (log_dyn[0] !== 16'hABCD) begin errors++; $display("FAIL single_dynreg: got %h want abcd", log_dyn[0]); end
    checks++; if (STATREG !== 88'h0123456789ABCDEFFEDCBA) begin errors++; $display("FAIL single_statreg: got %h want 0123456789abcdeffedcba", STATREG); end
    checks++; if (log_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_after_start: got %b want 1", log_ready[0]); end
    checks++; if (log_busy[108] !== 1'b0) begin errors++; $display("FAIL single_idle_after: busy got %b want 0", log_busy[108]); end
  endtask

  task automatic test_back_to_back();
    DYN_VALID = 1'b1; DYN_DATA = 16'h0001;
    @(negedge CLK);
    DYN_VALID = 1'b0;
    STAT_DATA = 88'hA5A5A5A5A5A5A5A5A5A5A5;
    START = 1'b1;
    // 0001 preloaded; nothing for frame 2 (underrun); 0002 fed during frame 2
    run_window(330, 216, 150, 16'h0002);
    checks++; if (n_busy !== 324) begin errors++; $display("FAIL b2b_busy_len: got %0d want 324", n_busy); end
    checks++; if (n_stat !== 264 || n_dyn !== 48) begin errors++; $display("FAIL b2b_sel_len: stat %0d dyn %0d want 264 48", n_stat, n_dyn); end
    checks++; if (log_done[107] !== 1'b1 || log_stat[108] !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: done107 %b stat108 %b want 1 1", log_done[107], log_stat[108]); end
    checks++; if (n_done !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    checks++; if (log_dyn[0] !== 16'h0001) begin errors++; $display("FAIL b2b_dyn_f1: got %h want 0001", log_dyn[0]); end
    checks++; if (n_under !== 1 || log_under[108] !== 1'b1) begin errors++; $display("FAIL b2b_underrun: count %0d at108 %b want 1 1", n_under, log_under[108]); end
    checks++; if (log_dyn[108] !== 16'h0001) begin errors++; $display("FAIL b2b_dyn_hold: got %h want 0001", log_dyn[108]); end
    checks++; if (log_ready[151] !== 1'b0) begin errors++; $display("FAIL b2b_buffer_fill: ready got %b want 0", log_ready[151]); end
    checks++; if (log_dyn[215] !== 16'h0001) begin errors++; $display("FAIL b2b_dyn_stable: got %h want 0001", log_dyn[215]); end
    checks++; if (log_dyn[216] !== 16'h0002) begin errors++; $display("FAIL b2b_dyn_f3: got %h want 0002", log_dyn[216]); end
    checks++; if (log_busy[324] !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy got %b want 0", log_busy[324]); end
  endtask

  task automatic test_bypass();
    START = 1'b1; DYN_VALID = 1'b1; DYN_DATA = 16'h5A5A;
    run_window(110, 0, -1, 16'h0);
    checks++; if (log_dyn[0] !== 16'h5A5A) begin errors++; $display("FAIL bypass_dynreg: got %h want 5a5a", log_dyn[0]); end
    checks++; if (n_under !== 0) begin errors++; $display("FAIL bypass_underrun: got %0d want 0", n_under); end
    checks++; if (log_ready[0] !== 1'b1 || log_ready[1] !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b%b want 11", log_ready[0], log_ready[1]); end
  endtask

  task automatic test_full_buffer();
    DYN_VALID = 1'b1; DYN_DATA = 16'h1234;
    @(negedge CLK);
    checks++; if (DYN_READY !== 1'b0) begin errors++; $display("FAIL full_ready_first: got %b want 0", DYN_READY); end
    DYN_DATA = 16'hFFFF;
    repeat (2) @(negedge CLK);
    checks++; if (DYN_READY !== 1'b0) begin errors++; $display("FAIL full_ready_held: got %b want 0", DYN_READY); end
    DYN_VALID = 1'b0;
    STAT_DATA = 88'h1;
    START = 1'b1;
    run_window(110, 0, -1, 16'h0);
    checks++; if (log_dyn[0] !== 16'h1234) begin errors++; $display("FAIL full_no_overwrite: got %h want 1234", log_dyn[0]); end
    checks++; if (log_ready[0] !== 1'b1) begin errors++; $display("FAIL full_emptied: ready got %b want 1", log_ready[0]); end
    checks++; if (STATREG !== 88'h1) begin errors++; $display("FAIL full_statreg: got %h want 1", STATREG); end
  endtask

  task automatic test_reset_mid_frame();
    STAT_DATA = 88'hFF;
    START = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      @(negedge CLK);
      if (i == 50) begin
        checks++; if (SELSTAT !== 1'b1) begin errors++; $display("FAIL midrst_in_stat: got %b want 1", SELSTAT); end
        RST_N = 1'b0;
      end
    end
    @(negedge CLK);
    checks++; if (SELSTAT !== 1'b0 || SELDYN !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL midrst_state: selstat %b seldyn %b busy %b want 0 0 0", SELSTAT, SELDYN, BUSY); end
    checks++; if (STATREG !== 88'h0 || DYNREG !== 16'h0) begin errors++; $display("FAIL midrst_regs: statreg %h dynreg %h want 0 0", STATREG, DYNREG); end
    checks++; if (DYN_READY !== 1'b1 || UNDERRUN !== 1'b0 || FRAME_DONE !== 1'b0) begin errors++; $display("FAIL midrst_flags: ready %b under %b done %b want 1 0 0", DYN_READY, UNDERRUN, FRAME_DONE); end
    RST_N = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy got %b want 0", BUSY); end
    START = 1'b1;
    // START dropped mid-DYN: frame must still run its full 108 cycles
    run_window(112, 95, -1, 16'h0);
    checks++; if (log_stat[0] !== 1'b1) begin errors++; $display("FAIL restart_stat: got %b want 1", log_stat[0]); end
    checks++; if (n_busy !== 108 || done_idx !== 107) begin errors++; $display("FAIL stop_mid_dyn: busy %0d done_at %0d want 108 107", n_busy, done_idx); end
    checks++; if (log_busy[108] !== 1'b0 || log_stat[108] !== 1'b0) begin errors++; $display("FAIL stop_to_idle: busy %b stat %b want 0 0", log_busy[108], log_stat[108]); end
    checks++; if (n_under !== 1) begin errors++; $display("FAIL restart_underrun: got %0d want 1", n_under); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bypass();
    test_full_buffer();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
